// File: rtl/riscv_immext_pipe_if.sv
// Request/response bundle for the pipelined RISC-V immediate extender.
// Signal names are taken from the extender's point of view: i_* flow into it, o_* flow out of it.
interface riscv_immext_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_instr;
  logic [2:0]        i_imm_src;
  logic [TAG_W-1:0]  i_tag;
  logic              o_valid;
  logic              i_ready;
  logic [XLEN-1:0]   o_imm;
  logic [TAG_W-1:0]  o_tag;
  logic              o_err;

  // The extender itself.
  modport slave (
    input  i_flush, i_valid, i_instr, i_imm_src, i_tag, i_ready,
    output o_ready, o_valid, o_imm, o_tag, o_err
  );

  // The decoder that issues requests and the execute stage that consumes results.
  modport master (
    output i_flush, i_valid, i_instr, i_imm_src, i_tag, i_ready,
    input  o_ready, o_valid, o_imm, o_tag, o_err
  );
endinterface

// File: rtl/riscv_immext_pipe.sv
// Pipelined RV32I/RV64I immediate extender: combinational extension into a
// small circular result buffer with valid/ready on both sides, flush and tag sideband.
module riscv_immext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  riscv_immext_pipe_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_Z   = 3'd5,
    FMT_SH  = 3'd6,
    FMT_ILL = 3'd7
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  entry_t             head;
  entry_t             wr_entry;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  imm_fmt_e           fmt;
  logic               sgn;
  logic [31:0]        sext32;
  logic [XLEN-1:0]    sext_imm;
  logic [5:0]         shamt;
  logic [XLEN-1:0]    ext_imm;
  logic               ext_err;
  logic               unused_opcode;

  assign fmt           = imm_fmt_e'(bus.i_imm_src);
  assign sgn           = bus.i_instr[31];
  assign unused_opcode = ^bus.i_instr[6:0];

  // RV64 shifts take a 6-bit shamt; RV32 only the low 5 bits are meaningful.
  assign shamt = (XLEN == 64) ? bus.i_instr[25:20] : {1'b0, bus.i_instr[24:20]};

  // Every signed format is first built as a 32-bit value, then widened by bit 31.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sext32 = '0;
    case (fmt)
      FMT_I:   sext32 = {{20{sgn}}, bus.i_instr[31:20]};
      FMT_S:   sext32 = {{20{sgn}}, bus.i_instr[31:25], bus.i_instr[11:7]};
      FMT_B:   sext32 = {{19{sgn}}, bus.i_instr[31], bus.i_instr[7],
                         bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
      FMT_U:   sext32 = {bus.i_instr[31:12], 12'b0};
      FMT_J:   sext32 = {{11{sgn}}, bus.i_instr[31], bus.i_instr[19:12],
                         bus.i_instr[20], bus.i_instr[30:21], 1'b0};
      default: sext32 = '0;
    endcase
  end

  assign sext_imm = {{(XLEN-31){sext32[31]}}, sext32[30:0]};

  always_comb begin
    ext_imm = '0;
    ext_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S, FMT_B, FMT_U, FMT_J: ext_imm = sext_imm;
      FMT_Z:   ext_imm = {{(XLEN-5){1'b0}}, bus.i_instr[19:15]};
      FMT_SH:  ext_imm = {{(XLEN-6){1'b0}}, shamt};
      default: ext_err = 1'b1;
    endcase
  end

  assign wr_entry = '{imm: ext_imm, tag: bus.i_tag, err: ext_err};

  // Handshake qualifiers come from registered occupancy only, so i_ready never reaches o_ready.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.i_valid && !full && !bus.i_flush;
  assign pop   = !empty && bus.i_ready && !bus.i_flush;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the entry storage is cleared on reset too, so no stale result survives a reset.
      mem    <= '0;
    end else if (bus.i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  assign bus.o_ready = !full;
  assign bus.o_valid = !empty;
  assign bus.o_imm   = empty ? '0 : head.imm;
  assign bus.o_tag   = empty ? '0 : head.tag;
  assign bus.o_err   = empty ? 1'b0 : head.err;
endmodule
